dram_mport_clr: RTL
===================

# dram_mport_clr

Parametrised multi-read-port distributed RAM with a built-in range-clear engine. It is the successor to the fixed three-port storage used for intra pred modes, ref_idx and mvp. The number of read ports is a parameter. A sequential clear engine can wipe any address range, with wrap-around, to a supplied value between CTUs. Decoder blocks use it for per-CTU side-information storage that must be reinitialised without a separate write master.

## Interface
- addr_bits, 6, address width; depth = 1<<addr_bits
- data_bits, 8, entry width
- read_ports, 3, number of asynchronous read ports (>=1)

- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- en  input  1  global enable; gates user writes and clear progress
- we  input  1  user write strobe
- addrd  input  addr_bits  user write address
- did  input  data_bits  user write data
- addr_r  input  read_ports*addr_bits  packed read addresses; port k at [k*addr_bits +: addr_bits]
- do_r  output  read_ports*data_bits  packed read data, combinational
- clr_start  input  1  single-cycle clear request
- clr_base  input  addr_bits  first address to clear
- clr_len  input  addr_bits  entry count; 0 means full depth
- clr_val  input  data_bits  value written by the clear engine
- clr_busy  output  1  clear engine active; reset 0
- clr_done  output  1  one-cycle pulse after the final clear write; reset 0

## Operation
- Storage is distributed RAM. There is one write port and read_ports combinational read ports, so do_r[k] = ram[addr_r[k]].
- The FSM has two states, IDLE and CLEAR.
- IDLE:
  - A user write occurs on each edge with en && we: ram[addrd] <= did.
  - On clr_start at an edge, the engine latches ptr=clr_base, clr_val, and cnt=clr_len (0 maps to 1<<addr_bits, so cnt is addr_bits+1 bits wide), then enters CLEAR.
  - A user write in the same cycle as clr_start is still performed.
- CLEAR:
  - On each edge with en: ram[ptr] <= latched clr_val, ptr <= ptr+1 mod depth (wraps past top), cnt <= cnt-1.
  - When cnt==1, that write is the last one; the FSM goes to IDLE and asserts clr_done for the next cycle.
  - en low holds ptr, cnt and state.
- User writes during CLEAR are dropped. The clear engine owns the write port. Issuers must poll clr_busy.
- clr_start during CLEAR is ignored.
- Reads during CLEAR return current contents: already-cleared entries show clr_val, the rest show old data.
- rst:
  - FSM goes to IDLE; clr_busy and clr_done go to 0; ptr and cnt go to 0.
  - RAM contents are not reset.
  - rst mid-clear aborts the clear immediately; no write occurs on the reset edge; entries already cleared stay cleared.
- rst has priority over clr_start in the same cycle.

## Timing
- Read latency is 0 cycles (combinational). Write-to-read visibility is the cycle after the write edge, unless the bypass feature is enabled.
- clr_start sampled at edge N gives clr_busy=1 from cycle N+1. Writes happen at edges N+1 through N+L (L = effective length, en held high).
- After edge N+L, clr_busy=0 and clr_done=1 for exactly one cycle. The next clr_start can be accepted at edge N+L+1.
- A full-depth clear with default parameters takes 64 enabled cycles.

## Configuration
- DRAM_MPORT_BYPASS_EN:
  - Defined: any read port whose address equals the active write address in a cycle with an active write returns the write data combinationally. The active write is either the user write (en&&we in IDLE) or the clear write (en in CLEAR), so the write data is did or clr_val respectively.
  - Not defined: that port returns the pre-write contents, as for a plain distributed RAM.

## Structure
- Shared package dram_pkg holds the state typedef (IDLE, CLEAR) and the helper constant for depth = 1<<addr_bits.
- Sub-module dram_clr_fsm holds the FSM, ptr, cnt, the latched clr_val, clr_busy and clr_done. It outputs wr_sel, wr_addr and wr_data to the RAM array in the top.

## Test plan
- Write 0x11 @5, 0x22 @6, read ports 0..2 at addresses 5, 6, 5 -> 0x11, 0x22, 0x11 on the cycle after the writes.
- Range clear:
  - Stimulus: fill all entries with 0xAA, then clr_start with base=60, len=8, val=0x00.
  - Required: clr_busy for 8 cycles; addresses 60..63 and 0..3 read 0x00; 4 and 59 read 0xAA; clr_done pulses exactly once.
- Full clear with len=0 -> 64 busy cycles. Drop en for 3 cycles mid-clear -> 67 busy cycles, and all entries equal clr_val.
- During clear, we=1 to address 10 with data 0x55 -> write dropped, so address 10 reads clr_val. A second clr_start is ignored, so the busy length is unchanged.
- Reset mid-clear:
  - Stimulus: rst asserted after 4 clear writes.
  - Required: clr_busy=0 next cycle and no clr_done; entries base..base+3 cleared, base+4 unchanged.
- With DRAM_MPORT_BYPASS_EN, a write of 0x77 @9 while addr_r[1]=9 -> do_r[1]=0x77 in the same cycle. Without the macro -> the old value.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and helpers for the multi-port distributed RAM with clear engine.
package dram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Number of entries for a given address width.
    function automatic int dram_depth(input int ab);
        return 1 << ab;
    endfunction

endpackage

// File: rtl/dram_clr_fsm.sv
// Range-clear engine. It owns the RAM write port and arbitrates between user
// writes (IDLE) and clear writes (CLEAR). A clear wraps past the top address.
module dram_clr_fsm
    import dram_pkg::*;
#(
    parameter int addr_bits = 6,
    parameter int data_bits = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  logic [addr_bits-1:0] addrd,
    input  logic [data_bits-1:0] did,
    input  logic                 clr_start,
    input  logic [addr_bits-1:0] clr_base,
    input  logic [addr_bits-1:0] clr_len,
    input  logic [data_bits-1:0] clr_val,
    output logic                 wr_sel,
    output logic [addr_bits-1:0] wr_addr,
    output logic [data_bits-1:0] wr_data,
    output logic                 clr_busy,
    output logic                 clr_done
);

    // A length of 0 selects the whole array, so cnt needs one extra bit.
    localparam logic [addr_bits:0] CNT_FULL = (addr_bits+1)'(dram_depth(addr_bits));
    localparam logic [addr_bits:0] CNT_ONE  = (addr_bits+1)'(1);

    clr_state_t           state, state_n;
    logic [addr_bits-1:0] ptr, ptr_n;
    logic [addr_bits:0]   cnt, cnt_n;
    logic [data_bits-1:0] val_q, val_n;
    logic                 done_n;

    // State register; reset aborts any clear in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            val_q    <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            val_q    <= val_n;
            clr_done <= done_n;
        end
    end

    // Next-state: latch a request in IDLE, step pointer/count in CLEAR while enabled.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        val_n   = val_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    ptr_n   = clr_base;
                    val_n   = clr_val;
                    cnt_n   = (clr_len == '0) ? CNT_FULL : {1'b0, clr_len};
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                if (en) begin
                    ptr_n = ptr + 1'b1;
                    cnt_n = cnt - 1'b1;
                    if (cnt == CNT_ONE) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Write-port mux; user writes are dropped while clearing and nothing is
    // written on a reset edge.
    always_comb begin
        wr_sel  = 1'b0;
        wr_addr = addrd;
        wr_data = did;
        if (!rst && en) begin
            if (state == CLEAR) begin
                wr_sel  = 1'b1;
                wr_addr = ptr;
                wr_data = val_q;
            end else begin
                wr_sel  = we;
            end
        end
    end

    assign clr_busy = (state == CLEAR);

endmodule

// File: rtl/dram_mport_clr.sv
// Multi-read-port distributed RAM with a built-in range-clear engine.
// Optional macro DRAM_MPORT_BYPASS_EN forwards the active write data to any
// read port addressing the written entry in the same cycle.
module dram_mport_clr
    import dram_pkg::*;
#(
    parameter int addr_bits  = 6,
    parameter int data_bits  = 8,
    parameter int read_ports = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            we,
    input  logic [addr_bits-1:0]            addrd,
    input  logic [data_bits-1:0]            did,
    input  logic [read_ports*addr_bits-1:0] addr_r,
    output logic [read_ports*data_bits-1:0] do_r,
    input  logic                            clr_start,
    input  logic [addr_bits-1:0]            clr_base,
    input  logic [addr_bits-1:0]            clr_len,
    input  logic [data_bits-1:0]            clr_val,
    output logic                            clr_busy,
    output logic                            clr_done
);

    localparam int DEPTH = dram_depth(addr_bits);

    logic                 wr_sel;
    logic [addr_bits-1:0] wr_addr;
    logic [data_bits-1:0] wr_data;

    logic [data_bits-1:0] ram [DEPTH];

    logic [read_ports-1:0][addr_bits-1:0] rd_addr;
    logic [read_ports-1:0][data_bits-1:0] rd_data;

    assign rd_addr = addr_r;
    assign do_r    = rd_data;

    dram_clr_fsm #(
        .addr_bits (addr_bits),
        .data_bits (data_bits)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .we        (we),
        .addrd     (addrd),
        .did       (did),
        .clr_start (clr_start),
        .clr_base  (clr_base),
        .clr_len   (clr_len),
        .clr_val   (clr_val),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    // Single write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_sel) ram[wr_addr] <= wr_data;
    end

    // Asynchronous read ports.
    for (genvar k = 0; k < read_ports; k++) begin : g_rd
`ifdef DRAM_MPORT_BYPASS_EN
        assign rd_data[k] = (wr_sel && (wr_addr == rd_addr[k])) ? wr_data : ram[rd_addr[k]];
`else
        assign rd_data[k] = ram[rd_addr[k]];
`endif
    end

endmodule
